// File: rtl/sar_search_core.sv
// Successive-approximation search: finds the largest X_W-bit code x with f(x) <= y_t,
// resolving one bit per clock, with selectable square / linear transfer function.
module sar_search_core #(
    parameter int X_W        = 4,
    parameter int Y_W        = 10,
    parameter int COEF       = 40,
    parameter int EARLY_EXIT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [Y_W-1:0] y_t,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           done,
    output logic           busy,
    output logic           exact
);

    localparam int CW    = $clog2(COEF + 1);
    localparam int SQ_W  = 2 * X_W;
    localparam int LN_W  = X_W + CW;
    localparam int FW    = (SQ_W > LN_W) ? SQ_W : LN_W;
    localparam int CMP_W = (FW > Y_W) ? FW : Y_W;

    localparam logic [X_W-1:0]   MSB  = {1'b1, {(X_W-1){1'b0}}};
    localparam logic [CMP_W-1:0] YMAX = CMP_W'({Y_W{1'b1}});

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t           state, state_nxt;
    logic [X_W-1:0]   mask, mask_nxt, x_nxt, x_cleared;
    logic [Y_W-1:0]   yt_q, y_nxt;
    logic             mode_q, mode_eval;
    logic             done_nxt, busy_nxt, exact_nxt, cap;
    logic             accept, hit, over, last, exact_last;
    logic [CMP_W-1:0] f_cur, f_nxt, yt_ext;

    // Evaluated at full precision; CMP_W always holds the exact product.
    function automatic logic [CMP_W-1:0] f_eval(input logic [X_W-1:0] xv, input logic m);
        logic [CMP_W-1:0] xe;
        xe = CMP_W'(xv);
        if (m) return xe * CMP_W'(COEF);
        else   return xe * xe;
    endfunction

    assign accept     = start && (state != SEARCH);
    assign yt_ext     = CMP_W'(yt_q);
    assign f_cur      = f_eval(x, mode_q);
    assign hit        = (EARLY_EXIT != 0) && (f_cur == yt_ext);
    assign over       = f_cur > yt_ext;
    assign last       = mask[0];
    assign x_cleared  = over ? (x & ~mask) : x;
    assign exact_last = (f_eval(x_cleared, mode_q) == yt_ext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = accept ? SEARCH : IDLE;
            SEARCH:     state_nxt = (hit || last) ? DONE : SEARCH;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        x_nxt     = x;
        mask_nxt  = mask;
        done_nxt  = 1'b0;
        busy_nxt  = busy;
        exact_nxt = exact;
        cap       = 1'b0;
        mode_eval = mode_q;
        if (accept) begin
            cap       = 1'b1;
            x_nxt     = MSB;
            mask_nxt  = MSB;
            busy_nxt  = 1'b1;
            exact_nxt = 1'b0;
            mode_eval = mode;
        end else if (state == SEARCH) begin
            if (hit) begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                exact_nxt = 1'b1;
            end else if (last) begin
                x_nxt     = x_cleared;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                exact_nxt = exact_last;
            end else begin
                x_nxt    = x_cleared | (mask >> 1);
                mask_nxt = mask >> 1;
            end
        end
    end

    // y tracks the registered x; saturation is display-only, never used for compare.
    assign f_nxt = f_eval(x_nxt, mode_eval);
    assign y_nxt = (f_nxt > YMAX) ? {Y_W{1'b1}} : f_nxt[Y_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x      <= '0;
            mask   <= '0;
            y      <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            exact  <= 1'b0;
            yt_q   <= '0;
            mode_q <= 1'b0;
        end else begin
            x     <= x_nxt;
            mask  <= mask_nxt;
            y     <= y_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
            exact <= exact_nxt;
            if (cap) begin
                yt_q   <= y_t;
                mode_q <= mode;
            end
        end
    end

endmodule

// File: tb/tb_sar_search_core.sv
// Scoreboard bench for sar_search_core: three instances (4-bit, 4-bit early-exit, 6-bit)
// checked against a brute-force largest-code model.
module tb_sar_search_core;

    typedef struct {
        int x;
        int y;
        int exact;
        int lat;
        int t0;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic [9:0] y_t = '0;
    logic       start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic [3:0] x_a, x_b;
    logic [5:0] x_c;
    logic [9:0] y_a, y_b, y_c;
    logic       done_a, done_b, done_c, busy_a, busy_b, busy_c, exact_a, exact_b, exact_c;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t q[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sar_search_core #(.X_W(4), .Y_W(10), .COEF(40), .EARLY_EXIT(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode), .y_t(y_t),
        .x(x_a), .y(y_a), .done(done_a), .busy(busy_a), .exact(exact_a));
    sar_search_core #(.X_W(4), .Y_W(10), .COEF(40), .EARLY_EXIT(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode), .y_t(y_t),
        .x(x_b), .y(y_b), .done(done_b), .busy(busy_b), .exact(exact_b));
    sar_search_core #(.X_W(6), .Y_W(10), .COEF(40), .EARLY_EXIT(0)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode), .y_t(y_t),
        .x(x_c), .y(y_c), .done(done_c), .busy(busy_c), .exact(exact_c));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_f(input int xv, input bit m);
        return m ? xv * 40 : xv * xv;
    endfunction

    // Largest code by exhaustive scan; early-exit latency from where that code first appears as a trial.
    function automatic exp_t model(input int xw, input bit m, input int yt, input bit ee);
        exp_t e;
        int   xr;
        int   f;
        int   p;
        xr = 0;
        for (int v = (1 << xw) - 1; v >= 0; v--) begin
            if (ref_f(v, m) <= yt) begin
                xr = v;
                break;
            end
        end
        f       = ref_f(xr, m);
        e.x     = xr;
        e.y     = (f > 1023) ? 1023 : f;
        e.exact = (f == yt) ? 1 : 0;
        e.lat   = xw;
        e.t0    = 0;
        if (ee && e.exact == 1 && xr != 0) begin
            p = 0;
            while (((xr >> p) & 1) == 0) p++;
            e.lat = xw - p;
        end
        return e;
    endfunction

    task automatic push(input int id, input bit m, input int yt);
        exp_t e;
        case (id)
            0:       e = model(4, m, yt, 1'b0);
            1:       e = model(4, m, yt, 1'b1);
            default: e = model(6, m, yt, 1'b0);
        endcase
        e.t0 = cyc + 1;
        q[id].push_back(e);
    endtask

    task automatic mon(input int id, input logic d, input int xv, input int yv,
                       input logic ex, input logic bs);
        exp_t e;
        if (d) begin
            if (q[id].size() == 0) begin
                chk($sformatf("done_unexpected[%0d]", id), d, 0);
            end else begin
                e = q[id].pop_front();
                chk($sformatf("x[%0d]", id), xv, e.x);
                chk($sformatf("y[%0d]", id), yv, e.y);
                chk($sformatf("exact[%0d]", id), ex, e.exact);
                chk($sformatf("latency[%0d]", id), cyc - e.t0, e.lat);
                chk($sformatf("busy_at_done[%0d]", id), bs, 0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, done_a, x_a, y_a, exact_a, busy_a);
        mon(1, done_b, x_b, y_b, exact_b, busy_b);
        mon(2, done_c, x_c, y_c, exact_c, busy_c);
    end

    // One-cycle start on the selected instances; returns just after the capture edge.
    task automatic go(input bit [2:0] msk, input bit m, input int yt);
        @(posedge clk); #2;
        mode    = m;
        y_t     = 10'(yt);
        start_a = msk[0];
        start_b = msk[1];
        start_c = msk[2];
        for (int i = 0; i < 3; i++) if (msk[i]) push(i, m, yt);
        @(posedge clk); #2;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        if (msk[0]) begin chk("busy_a", busy_a, 1); chk("trial0_a", x_a, 8);  end
        if (msk[1]) begin chk("busy_b", busy_b, 1); chk("trial0_b", x_b, 8);  end
        if (msk[2]) begin chk("busy_c", busy_c, 1); chk("trial0_c", x_c, 32); end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        chk("drain_timeout", q[0].size() + q[1].size() + q[2].size(), 0);
        @(posedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_x", x_a, 0);
        chk("rst_y", y_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_exact", exact_a, 0);
        rst = 1'b0;

        // Square, y_t=200: trial sequence 8,12,14,15 then result 14.
        go(3'b001, 1'b0, 200);
        @(negedge clk); chk("trace0", x_a, 8);
        @(negedge clk); chk("trace1", x_a, 12);
        @(negedge clk); chk("trace2", x_a, 14);
        @(negedge clk); chk("trace3", x_a, 15);
        chk("busy_trace", busy_a, 1);
        drain();

        // Linear 630 then 300 accepted in the done cycle.
        go(3'b001, 1'b1, 630);
        n = 0;
        while (n < 20) begin
            @(posedge clk); #2;
            if (done_a) break;
            n++;
        end
        chk("b2b_done_cycle", done_a, 1);
        y_t     = 10'd300;
        start_a = 1'b1;
        push(0, 1'b1, 300);
        @(posedge clk); #2;
        start_a = 1'b0;
        chk("b2b_busy", busy_a, 1);
        chk("b2b_trial", x_a, 8);
        drain();

        // Exact match with and without early exit; then the y_t=0 and saturation corners.
        go(3'b111, 1'b0, 64);
        drain();
        go(3'b111, 1'b0, 0);
        drain();
        go(3'b111, 1'b0, 1023);
        chk("sat_trial_y", y_c, 1023);
        drain();
        go(3'b111, 1'b1, 1023);
        drain();

        // start/y_t/mode disturbed mid-search must be ignored.
        go(3'b001, 1'b0, 200);
        @(posedge clk); #2;
        start_a = 1'b1;
        y_t     = 10'd10;
        mode    = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        start_a = 1'b0;
        drain();

        for (int i = 0; i < 6; i++) begin
            go(3'b111, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)));
            drain();
        end

        // Asynchronous reset between edges aborts without a done pulse.
        go(3'b111, 1'b0, 500);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_x", x_c, 0);
        chk("arst_y", y_c, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_done", done_b, 0);
        chk("arst_exact", exact_a, 0);
        for (int i = 0; i < 3; i++) q[i].delete();
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        go(3'b111, 1'b1, 300);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sar_search_core.md
Name: sar_search_core

Overview:
- Parametrised successive-approximation search engine; next generation of the fixed 4-bit/10-bit `sa` block.
- On `start`, it finds the largest code x, X_W bits wide, such that f(x) <= y_t, resolving one bit per clock. It then pulses `done`.
- New over `sa`:
  - generic widths;
  - run-time transfer-function select: square or linear with coefficient;
  - optional early exit on exact match;
  - `busy` and `exact` status outputs.
- Sits between the target-setting control logic and downstream consumers of x/y, as in the hw1 gate-level flow.

Parameters:
X_W, 4, width of search code x (>= 2)
Y_W, 10, width of target y_t and result y
COEF, 40, multiplier for linear mode (f(x) = x*COEF), unsigned
EARLY_EXIT, 0, 1 = terminate as soon as f(x) == y_t

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  search request, sampled on rising clk
mode  in  1  0: f(x)=x*x; 1: f(x)=x*COEF; captured with start
y_t  in  Y_W  target value, captured with start
x  out  X_W  current trial code / final result
y  out  Y_W  f(x) of current x, saturated to 2^Y_W-1
done  out  1  one-cycle pulse, result valid
busy  out  1  high while search in progress
exact  out  1  f(x_final) == y_t; valid with done, held until next start

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE; x=0, y=0, done=0, busy=0, exact=0; captured y_t/mode cleared.
  - Reset mid-search aborts with no done pulse.
- Arithmetic:
  - f computed at full precision: 2*X_W bits (square) or X_W+clog2(COEF+1) bits (linear).
  - Compared unsigned against zero-extended captured y_t.
  - Output y = min(f(x), 2^Y_W-1), registered alongside x, so it always reflects the current x.
- States: IDLE, SEARCH, DONE.
- IDLE/DONE with start=1 at edge E0:
  - capture y_t, mode;
  - x = 1<<(X_W-1); busy=1, done=0, exact=0;
  - go to SEARCH, k=1.
- SEARCH, edge E_k (k=1..X_W), bit b = X_W-k:
  - if EARLY_EXIT=1 and f(x)==y_t: keep x; done=1, exact=1, busy=0; go to DONE.
  - else, if f(x)>y_t, clear bit b.
  - if k<X_W, set bit b-1 and stay in SEARCH.
  - if k==X_W: done=1, busy=0, exact=(f(new x)==y_t); go to DONE.
- Latency: done is high in the cycle after E_X_W (X_W cycles after start is sampled), or earlier on early exit. Minimum is 1 cycle.
- DONE:
  - done=1 for exactly one cycle, then 0.
  - x, y, exact held until the next accepted start; state returns to IDLE.
  - start sampled in the done cycle is accepted as a new E0 (back-to-back searches).
- start while busy=1 is ignored; captured y_t/mode are unaffected by input changes during the search.
- f(0)=0 <= any y_t, so the result always exists. If y_t >= f(2^X_W-1), the result is x = all ones.
- y saturation affects only the y output, never the comparison.

Test Plan:
- X_W=4, mode=0, y_t=200, start 1 cycle:
  - x trace 8,12,14,15 -> final x=14, y=196, exact=0;
  - done pulses 4 cycles after start, busy high for those 4 cycles.
- mode=1, COEF=40:
  - y_t=630 -> x=15, y=600, exact=0.
  - Then y_t=300 started in the done cycle -> x=7, y=280; the new search is accepted back-to-back.
- mode=0, y_t=64:
  - EARLY_EXIT=0 -> trace 8,12,10,9 -> x=8, y=64, exact=1, done after 4 cycles.
  - EARLY_EXIT=1 -> done one cycle after start with x=8, exact=1.
- X_W=6, Y_W=10, mode=0:
  - y_t=1023 -> x=31, y=961.
  - Mid-search trial x=32 must show y=1023 (saturated) yet compare as 1024>1023.
- start re-asserted and y_t changed during SEARCH -> ignored, result unchanged.
- rst asserted asynchronously mid-search (between edges) -> x, y, done, busy, exact go to 0 immediately, with no done pulse. After release, a new start works normally.
